fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC, runs a one-outstanding-request handshake to instruction memory, and delivers {pc, instr, valid} to decode.
- Consumes the hazard unit's active-low controls (pc_enable, stall_ID, flush_ID) and the EX-stage redirect (i_pc_sel + target).
- Inserts bubbles while memory is slow; buffers one instruction while decode is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) loaded into IF/ID on bubble or flush.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_pc_sel  in  1  1 = redirect to i_pc_target this cycle (taken branch/jump).
- i_pc_target  in  32  redirect target from EX.
- i_pc_enable  in  1  0 = PC must not advance (hazard unit pc_enable).
- i_stall_id  in  1  0 = hold IF/ID (hazard unit stall_ID, active-low).
- i_flush_id  in  1  0 = load bubble into IF/ID (hazard unit flush_ID, active-low).
- o_imem_req  out  1  fetch request level.
- o_imem_addr  out  32  fetch address, stable while o_imem_req=1 until i_imem_rvalid.
- i_imem_rvalid  in  1  response valid, 1-cycle pulse, at most one per request.
- i_imem_rdata  in  32  instruction word, valid with i_imem_rvalid.
- o_id_pc  out  32  PC of instruction in IF/ID.
- o_id_instr  out  32  instruction in IF/ID.
- o_id_valid  out  1  1 = IF/ID holds a real instruction.

Behaviour:
- Reset (i_rst_n=0 at edge):
  - pc_q=RESET_PC, addr_q=RESET_PC, state=FETCH, buffer empty.
  - o_id_pc=0, o_id_instr=NOP_INSTR, o_id_valid=0.
  - o_imem_req=1 from the first cycle after reset.
- advance = i_pc_enable & i_stall_id.
- Priority per cycle: reset > redirect (i_pc_sel) > flush (i_flush_id=0) > stall (i_stall_id=0) > normal.
- States:
  - FETCH: o_imem_req=1, o_imem_addr=addr_q.
    - rvalid & redirect: drop data; pc_q=addr_q=target; IF/ID=bubble; stay FETCH.
    - rvalid & advance: IF/ID={addr_q, rdata, 1}; pc_q=addr_q=pc_q+4; stay FETCH. Back-to-back 1-cycle memory gives 1 instr/cycle.
    - rvalid & !advance: buffer=rdata; go HOLD; pc_q unchanged.
    - !rvalid & redirect: pc_q=target, addr_q held; go DROP; IF/ID=bubble.
    - !rvalid & no redirect: IF/ID=bubble if i_stall_id=1 (or flush), else hold.
  - HOLD: o_imem_req=0.
    - redirect: discard buffer; pc_q=addr_q=target; IF/ID=bubble; go FETCH.
    - advance: IF/ID={pc_q, buffer, 1}; pc_q=addr_q=pc_q+4; go FETCH.
    - otherwise: stay HOLD.
  - DROP: o_imem_req=1, o_imem_addr=addr_q (stale address, held stable).
    - rvalid: discard data; addr_q=pc_q; go FETCH.
    - A further redirect in DROP only updates pc_q.
- i_flush_id=0 without redirect: IF/ID=bubble, overriding stall. FETCH/HOLD data is not discarded; PC still obeys advance.
- Stall with i_flush_id=1: IF/ID registers unchanged.
- PC arithmetic: 32-bit, +4 wraps at 2^32. Target bits[1:0] pass through unmodified.
- Bubble = {o_id_pc unchanged, NOP_INSTR, valid=0}.
- Reset asserted mid-request: state returns to FETCH at RESET_PC. Memory is required to be reset by the same i_rst_n, so no stale response arrives.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds o_bubble_cnt (out, 32): cycles IF/ID loaded with a bubble due to memory not responding.
  - Adds o_drop_cnt (out, 32): responses discarded in FETCH-redirect or DROP.
  - Both reset to 0, saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package core_pkg:
  - fetch_state_t enum {FETCH, HOLD, DROP}.
  - NOP_INSTR constant.
  - Opcode constants (R_type, I_type_load, B_type, JAL, JALR, ...), replacing per-file defines.
- One sub-module, if_id_reg: the IF/ID register with load/hold/bubble select, reused by the stage and by bench-level pipeline models.

Test Plan:
- Reset, memory answers every cycle -> imem addrs 0,4,8,...; IF/ID valid=1 with pc 0,4,8 one cycle after each rvalid.
- i_stall_id=0 and i_pc_enable=0 for 2 cycles while rvalid for pc 8 -> state HOLD, req=0, IF/ID holds pc 4; on release IF/ID={8, buffered word, 1}, next addr 12.
- Redirect i_pc_sel=1, target 32'h100 while request for pc 12 outstanding (rvalid 3 cycles later) -> DROP; addr stays 12 until rvalid; that word never reaches IF/ID; next req addr 32'h100.
- Redirect coincident with rvalid in FETCH -> data dropped, IF/ID bubble (NOP, valid=0), next addr = target.
- i_flush_id=0 with i_stall_id=0 -> IF/ID becomes NOP/valid=0.
- With FETCH_PERF_CNT_EN: memory latency 3 for 2 instrs plus 1 drop -> o_bubble_cnt=4 (2 waiting cycles per instruction), o_drop_cnt=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: fetch FSM states, the NOP encoding,
// base opcodes and a small PC helper.
package core_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE_ALU  = 7'b0010011;
  localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE      = 7'b0100011;
  localparam logic [6:0] B_TYPE      = 7'b1100011;
  localparam logic [6:0] JAL         = 7'b1101111;
  localparam logic [6:0] JALR        = 7'b1100111;
  localparam logic [6:0] LUI         = 7'b0110111;
  localparam logic [6:0] AUIPC       = 7'b0010111;
  localparam logic [6:0] SYSTEM      = 7'b1110011;

  // Sequential PC, wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold, or insert a bubble
// (keeps PC, forces NOP, clears valid). Bubble wins over load.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  // Select between hold, bubble and load.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (i_bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (i_load) begin
      pc_d    = i_pc;
      instr_d = i_instr;
      valid_d = 1'b1;
    end
  end

  // Register update with synchronous reset to an empty slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q    <= 32'd0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign o_pc    = pc_q;
  assign o_instr = instr_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register. One outstanding imem request;
// HOLD buffers a word while decode is stalled, DROP waits out a response made
// stale by a redirect. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pc_sel,
  input  logic [31:0] i_pc_target,
  input  logic        i_pc_enable,
  input  logic        i_stall_id,
  input  logic        i_flush_id,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr,
  output logic        o_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_bubble_cnt,
  output logic [31:0] o_drop_cnt
`endif
);

  import core_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  buf_q, buf_d;

  logic        advance, flush;
  logic        ifid_load, ifid_bubble;
  logic [31:0] ifid_pc, ifid_instr;
  logic        mem_bubble, resp_dropped;

  // Next-state, PC/address update and IF/ID select.
  always_comb begin
    advance      = i_pc_enable & i_stall_id;
    flush        = ~i_flush_id;
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    ifid_load    = 1'b0;
    ifid_pc      = pc_q;
    ifid_instr   = i_imem_rdata;
    mem_bubble   = 1'b0;
    resp_dropped = 1'b0;
    o_imem_req   = 1'b0;
    case (state_q)
      FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_rvalid) begin
          if (i_pc_sel) begin
            pc_d         = i_pc_target;
            addr_d       = i_pc_target;
            resp_dropped = 1'b1;
          end else if (advance) begin
            ifid_load  = 1'b1;
            ifid_pc    = addr_q;
            ifid_instr = i_imem_rdata;
            pc_d       = pc_plus4(pc_q);
            addr_d     = pc_plus4(pc_q);
          end else begin
            buf_d   = i_imem_rdata;
            state_d = HOLD;
          end
        end else if (i_pc_sel) begin
          // Request stays outstanding at the old address until it answers.
          pc_d    = i_pc_target;
          state_d = DROP;
        end else begin
          mem_bubble = i_stall_id & ~flush;
        end
      end
      HOLD: begin
        if (i_pc_sel) begin
          pc_d    = i_pc_target;
          addr_d  = i_pc_target;
          state_d = FETCH;
        end else if (advance) begin
          ifid_load  = 1'b1;
          ifid_pc    = pc_q;
          ifid_instr = buf_q;
          pc_d       = pc_plus4(pc_q);
          addr_d     = pc_plus4(pc_q);
          state_d    = FETCH;
        end
      end
      DROP: begin
        o_imem_req = 1'b1;
        if (i_pc_sel) pc_d = i_pc_target;
        if (i_imem_rvalid) begin
          addr_d       = i_pc_sel ? i_pc_target : pc_q;
          resp_dropped = 1'b1;
          state_d      = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    // Redirect and flush always bubble; otherwise bubble when decode is free
    // but nothing new is being loaded.
    ifid_bubble = i_pc_sel | flush | (~ifid_load & i_stall_id);
  end

  // Control state with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Buffered instruction word; only meaningful in HOLD.
  always_ff @(posedge i_clk) begin
    buf_q <= buf_d;
  end

  assign o_imem_addr = addr_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (ifid_load),
    .i_bubble(ifid_bubble),
    .i_pc    (ifid_pc),
    .i_instr (ifid_instr),
    .o_pc    (o_id_pc),
    .o_instr (o_id_instr),
    .o_valid (o_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Saturating event counters.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (mem_bubble && bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (resp_dropped && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bubble_cnt_q <= 32'd0;
      drop_cnt_q   <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign o_bubble_cnt = bubble_cnt_q;
  assign o_drop_cnt   = drop_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = mem_bubble ^ resp_dropped;
`endif

endmodule
